datapath: RTL and testbench

- 32-bit single-bus CPU datapath for the Phase 1 processor.
- Contents: 16 general registers, HI/LO, PC, IR, MAR, MDR, Y, a 64-bit Z, and an ALU.
- A one-hot bus multiplexer is driven by external control signals; at this phase a testbench acts as the control unit.
- Every register state is exported for observation.

---
 rtl/datapath.sv | 253 +++++++++++++++++++++++++
 tb/tb_datapath.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: 16 general registers, HI/LO, PC, IR, MAR,
// MDR, Y, a double-width Z and the ALU. Control comes from outside the block.
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               R0in,
    input  logic               R1in,
    input  logic               R2in,
    input  logic               R3in,
    input  logic               R4in,
    input  logic               R5in,
    input  logic               R6in,
    input  logic               R7in,
    input  logic               R8in,
    input  logic               R9in,
    input  logic               R10in,
    input  logic               R11in,
    input  logic               R12in,
    input  logic               R13in,
    input  logic               R14in,
    input  logic               R15in,
    input  logic               HIin,
    input  logic               LOin,
    input  logic               PCin,
    input  logic               IRin,
    input  logic               Yin,
    input  logic               Zin,
    input  logic               MARin,
    input  logic               MDRin,
    input  logic               R0out,
    input  logic               R1out,
    input  logic               R2out,
    input  logic               R3out,
    input  logic               R4out,
    input  logic               R5out,
    input  logic               R6out,
    input  logic               R7out,
    input  logic               R8out,
    input  logic               R9out,
    input  logic               R10out,
    input  logic               R11out,
    input  logic               R12out,
    input  logic               R13out,
    input  logic               R14out,
    input  logic               R15out,
    input  logic               HIout,
    input  logic               LOout,
    input  logic               Zhighout,
    input  logic               Zlowout,
    input  logic               PCout,
    input  logic               MDRout,
    input  logic               InPortout,
    input  logic               Cout,
    input  logic               IncPC,
    input  logic               ADD,
    input  logic               SUB,
    input  logic               AND,
    input  logic               OR,
    input  logic               SHR,
    input  logic               SHRA,
    input  logic               SHL,
    input  logic               ROR,
    input  logic               ROL,
    input  logic               NEG,
    input  logic               NOT,
    input  logic               MUL,
    input  logic               DIV,
    input  logic               Read,
    input  logic [WIDTH-1:0]   Mdatain,
    output logic [WIDTH-1:0]   R0,
    output logic [WIDTH-1:0]   R1,
    output logic [WIDTH-1:0]   R2,
    output logic [WIDTH-1:0]   R3,
    output logic [WIDTH-1:0]   R4,
    output logic [WIDTH-1:0]   R5,
    output logic [WIDTH-1:0]   R6,
    output logic [WIDTH-1:0]   R7,
    output logic [WIDTH-1:0]   R8,
    output logic [WIDTH-1:0]   R9,
    output logic [WIDTH-1:0]   R10,
    output logic [WIDTH-1:0]   R11,
    output logic [WIDTH-1:0]   R12,
    output logic [WIDTH-1:0]   R13,
    output logic [WIDTH-1:0]   R14,
    output logic [WIDTH-1:0]   R15,
    output logic [WIDTH-1:0]   HI,
    output logic [WIDTH-1:0]   LO,
    output logic [WIDTH-1:0]   PC_out,
    output logic [WIDTH-1:0]   IR,
    output logic [WIDTH-1:0]   MAR,
    output logic [WIDTH-1:0]   Y,
    output logic [2*WIDTH-1:0] Z,
    output logic [WIDTH-1:0]   BusMuxOut_signal
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [15:0]        r_in;
    logic [15:0]        r_out;
    logic [WIDTH-1:0]   r_q [16];
    logic [WIDTH-1:0]   r_d [16];
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
    logic [WIDTH-1:0]   mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0]   bus;
    logic [2*WIDTH-1:0] alu_res;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    // Bus source select: lowest-numbered general register wins, then the fixed order of specials.
    always_comb begin
        logic             gpr_hit;
        logic [WIDTH-1:0] gpr_val;
        gpr_hit = 1'b0;
        gpr_val = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) begin
                gpr_hit = 1'b1;
                gpr_val = r_q[i];
            end
        end
        bus = '0;
        if (gpr_hit)                bus = gpr_val;
        else if (HIout)             bus = hi_q;
        else if (LOout)             bus = lo_q;
        else if (Zhighout)          bus = z_q[2*WIDTH-1:WIDTH];
        else if (Zlowout)           bus = z_q[WIDTH-1:0];
        else if (PCout)             bus = pc_q;
        else if (MDRout)            bus = mdr_q;
        else if (InPortout || Cout) bus = '0;   // no in-port or constant source yet
        else                        bus = '0;
    end

    // ALU operands and per-operation results; A is Y, B is the bus.
    logic [WIDTH-1:0]          a, b;
    logic signed [WIDTH-1:0]   a_s, b_s;
    logic [SW-1:0]             shamt;
    logic [2*WIDTH-1:0]        dbl;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   quot, rem;

    assign a     = y_q;
    assign b     = bus;
    assign a_s   = y_q;
    assign b_s   = bus;
    assign shamt = bus[SW-1:0];
    assign dbl   = {y_q, y_q};
    assign prod  = (2*WIDTH)'(a_s) * (2*WIDTH)'(b_s);
    assign quot  = a_s / b_s;
    assign rem   = a_s % b_s;

    // ALU result mux with fixed operation priority; single-word results zero-extend.
    always_comb begin
        logic [WIDTH-1:0] lo_res;
        logic             wide;
        lo_res  = '0;
        wide    = 1'b0;
        alu_res = '0;
        if (IncPC)      lo_res = b + ONE;
        else if (ADD)   lo_res = a + b;
        else if (SUB)   lo_res = a - b;
        else if (AND)   lo_res = a & b;
        else if (OR)    lo_res = a | b;
        else if (SHR)   lo_res = a >> shamt;
        else if (SHRA)  lo_res = a_s >>> shamt;
        else if (SHL)   lo_res = a << shamt;
        else if (ROR)   lo_res = WIDTH'(dbl >> shamt);
        else if (ROL)   lo_res = WIDTH'((dbl << shamt) >> WIDTH);
        else if (NEG)   lo_res = -b;
        else if (NOT)   lo_res = ~b;
        else if (MUL) begin
            wide    = 1'b1;
            alu_res = prod;
        end else if (DIV) begin
            wide    = 1'b1;
            alu_res = (b == '0) ? '0 : {rem, quot};
        end
        if (!wide) alu_res = {{WIDTH{1'b0}}, lo_res};
    end

    // Next-state for every register: hold unless its load enable is set.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            r_d[i] = r_in[i] ? bus : r_q[i];
        end
        hi_d  = HIin  ? bus : hi_q;
        lo_d  = LOin  ? bus : lo_q;
        pc_d  = PCin  ? bus : pc_q;
        ir_d  = IRin  ? bus : ir_q;
        mar_d = MARin ? bus : mar_q;
        y_d   = Yin   ? bus : y_q;
        mdr_d = mdr_q;
        if (MDRin) mdr_d = Read ? Mdatain : bus;
        z_d   = Zin   ? alu_res : z_q;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    assign R0  = r_q[0];
    assign R1  = r_q[1];
    assign R2  = r_q[2];
    assign R3  = r_q[3];
    assign R4  = r_q[4];
    assign R5  = r_q[5];
    assign R6  = r_q[6];
    assign R7  = r_q[7];
    assign R8  = r_q[8];
    assign R9  = r_q[9];
    assign R10 = r_q[10];
    assign R11 = r_q[11];
    assign R12 = r_q[12];
    assign R13 = r_q[13];
    assign R14 = r_q[14];
    assign R15 = r_q[15];
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign PC_out = pc_q;
    assign IR     = ir_q;
    assign MAR    = mar_q;
    assign Y      = y_q;
    assign Z      = z_q;
    assign BusMuxOut_signal = bus;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath: the bench plays control unit and checks
// registers, bus and ALU results against hand-computed values.
module tb_datapath;

    localparam int OP_INC = 0,  OP_ADD = 1,  OP_SUB = 2,  OP_AND = 3,  OP_OR = 4;
    localparam int OP_SHR = 5,  OP_SHRA = 6, OP_SHL = 7,  OP_ROR = 8,  OP_ROL = 9;
    localparam int OP_NEG = 10, OP_NOT = 11, OP_MUL = 12, OP_DIV = 13;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] rin, rout;
    logic [13:0] ops;
    logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
    logic        Read;
    logic [31:0] Mdatain;
    logic [31:0] r_val [16];
    logic [31:0] hi_v, lo_v, pc_v, ir_v, mar_v, y_v, bus_v;
    logic [63:0] z_v;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    datapath #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .MARin(MARin), .MDRin(MDRin),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
        .IncPC(ops[OP_INC]), .ADD(ops[OP_ADD]), .SUB(ops[OP_SUB]), .AND(ops[OP_AND]),
        .OR(ops[OP_OR]), .SHR(ops[OP_SHR]), .SHRA(ops[OP_SHRA]), .SHL(ops[OP_SHL]),
        .ROR(ops[OP_ROR]), .ROL(ops[OP_ROL]), .NEG(ops[OP_NEG]), .NOT(ops[OP_NOT]),
        .MUL(ops[OP_MUL]), .DIV(ops[OP_DIV]),
        .Read(Read), .Mdatain(Mdatain),
        .R0(r_val[0]), .R1(r_val[1]), .R2(r_val[2]), .R3(r_val[3]),
        .R4(r_val[4]), .R5(r_val[5]), .R6(r_val[6]), .R7(r_val[7]),
        .R8(r_val[8]), .R9(r_val[9]), .R10(r_val[10]), .R11(r_val[11]),
        .R12(r_val[12]), .R13(r_val[13]), .R14(r_val[14]), .R15(r_val[15]),
        .HI(hi_v), .LO(lo_v), .PC_out(pc_v), .IR(ir_v), .MAR(mar_v), .Y(y_v),
        .Z(z_v), .BusMuxOut_signal(bus_v)
    );

    task automatic idle();
        rin = '0; rout = '0; ops = '0;
        HIin = 0; LOin = 0; PCin = 0; IRin = 0; Yin = 0; Zin = 0; MARin = 0; MDRin = 0;
        HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
        InPortout = 0; Cout = 0; Read = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        Read = 1; MDRin = 1; Mdatain = v;
        step();
        MDRout = 1; rin[idx] = 1;
        step();
    endtask

    task automatic load_y(input int idx);
        rout[idx] = 1; Yin = 1;
        step();
    endtask

    task automatic run_op(input int op, input int breg);
        rout[breg] = 1; ops[op] = 1; Zin = 1;
        step();
    endtask

    task automatic test_reset();
        idle();
        Mdatain = '0;
        clear = 0;
        #1 clear = 1;
        #2;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (r_val[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_r%0d: got %h expected 00000000", i, r_val[i]);
            end
        end
        tests_run++;
        if ({hi_v, lo_v, pc_v, ir_v, mar_v, y_v} !== '0) begin
            tests_failed++;
            $display("FAIL reset_special: got %h %h %h %h %h %h expected all zero",
                     hi_v, lo_v, pc_v, ir_v, mar_v, y_v);
        end
        tests_run++;
        if (z_v !== 64'h0 || bus_v !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_z_bus: got Z=%h bus=%h expected 0", z_v, bus_v);
        end
        @(negedge clock);
        clear = 0;
    endtask

    task automatic test_load();
        Read = 1; MDRin = 1; Mdatain = 32'hF000_0000;
        step();
        MDRout = 1; rin[0] = 1;
        #1;
        tests_run++;
        if (bus_v !== 32'hF000_0000) begin
            tests_failed++;
            $display("FAIL load_bus: got %h expected f0000000", bus_v);
        end
        step();
        tests_run++;
        if (r_val[0] !== 32'hF000_0000) begin
            tests_failed++;
            $display("FAIL load_r0: got %h expected f0000000", r_val[0]);
        end
    endtask

    task automatic test_shra();
        load_reg(4, 32'd4);
        load_y(0);
        tests_run++;
        if (y_v !== 32'hF000_0000) begin
            tests_failed++;
            $display("FAIL shra_y: got %h expected f0000000", y_v);
        end
        run_op(OP_SHRA, 4);
        tests_run++;
        if (z_v !== 64'h0000_0000_FF00_0000) begin
            tests_failed++;
            $display("FAIL shra_z: got %h expected 00000000ff000000", z_v);
        end
        Zlowout = 1; rin[7] = 1;
        step();
        tests_run++;
        if (r_val[7] !== 32'hFF00_0000) begin
            tests_failed++;
            $display("FAIL shra_r7: got %h expected ff000000", r_val[7]);
        end
        load_reg(0, 32'h8000_0000);
        load_y(0);
        run_op(OP_SHRA, 4);
        Zlowout = 1; rin[7] = 1;
        step();
        tests_run++;
        if (r_val[7] !== 32'hF800_0000 || z_v[63:32] !== 32'h0) begin
            tests_failed++;
            $display("FAIL shra_neg: got r7=%h zhi=%h expected f8000000 00000000",
                     r_val[7], z_v[63:32]);
        end
    endtask

    task automatic test_fetch();
        PCout = 1; MARin = 1; ops[OP_INC] = 1; Zin = 1;
        step();
        tests_run++;
        if (mar_v !== 32'h0 || z_v !== 64'h1) begin
            tests_failed++;
            $display("FAIL fetch_mar_z: got MAR=%h Z=%h expected 0 1", mar_v, z_v);
        end
        Zlowout = 1; PCin = 1;
        step();
        tests_run++;
        if (pc_v !== 32'h1) begin
            tests_failed++;
            $display("FAIL fetch_pc: got %h expected 00000001", pc_v);
        end
        Read = 1; MDRin = 1; Mdatain = 32'h1234_5678;
        step();
        MDRout = 1; IRin = 1;
        step();
        tests_run++;
        if (ir_v !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL fetch_ir: got %h expected 12345678", ir_v);
        end
    endtask

    task automatic test_shifts();
        int          op_t  [9];
        int          reg_t [9];
        logic [31:0] exp_t [9];
        op_t  = '{OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_SHRA, OP_SHR, OP_ROL, OP_SHL, OP_ROR};
        reg_t = '{2, 2, 2, 2, 2, 3, 3, 5, 5};
        exp_t = '{32'h4000_0000, 32'h0000_0002, 32'hC000_0000, 32'h0000_0003,
                  32'hC000_0000, 32'h8000_0001, 32'h8000_0001, 32'h0000_0002,
                  32'hC000_0000};
        load_reg(1, 32'h8000_0001);
        load_y(1);
        load_reg(2, 32'd1);
        load_reg(3, 32'd0);
        load_reg(5, 32'd33);
        for (int i = 0; i < 9; i++) begin
            run_op(op_t[i], reg_t[i]);
            tests_run++;
            if (z_v !== {32'h0, exp_t[i]}) begin
                tests_failed++;
                $display("FAIL shift_%0d (op %0d, R%0d): got %h expected %h",
                         i, op_t[i], reg_t[i], z_v, {32'h0, exp_t[i]});
            end
        end
    endtask

    task automatic test_logic_arith();
        int          op_t  [6];
        logic [31:0] exp_t [6];
        op_t  = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT};
        exp_t = '{32'h8000_0002, 32'h8000_0000, 32'h0000_0001,
                  32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        for (int i = 0; i < 6; i++) begin
            run_op(op_t[i], 2);
            tests_run++;
            if (z_v !== {32'h0, exp_t[i]}) begin
                tests_failed++;
                $display("FAIL alu_%0d (op %0d): got %h expected %h",
                         i, op_t[i], z_v, {32'h0, exp_t[i]});
            end
        end
    endtask

    task automatic test_priority();
        rout[2] = 1; ops[OP_ADD] = 1; ops[OP_SUB] = 1; Zin = 1;
        step();
        tests_run++;
        if (z_v !== 64'h0000_0000_8000_0002) begin
            tests_failed++;
            $display("FAIL prio_add_sub: got %h expected 0000000080000002", z_v);
        end
        rout[2] = 1; ops[OP_MUL] = 1; ops[OP_DIV] = 1; Zin = 1;
        step();
        tests_run++;
        if (z_v !== 64'hFFFF_FFFF_8000_0001) begin
            tests_failed++;
            $display("FAIL prio_mul_div: got %h expected ffffffff80000001", z_v);
        end
        rout[2] = 1; rout[1] = 1; HIout = 1;
        #1;
        tests_run++;
        if (bus_v !== 32'h8000_0001) begin
            tests_failed++;
            $display("FAIL prio_bus: got %h expected 80000001", bus_v);
        end
        idle();
        rout[2] = 1; Zin = 1;
        step();
        tests_run++;
        if (z_v !== 64'h0) begin
            tests_failed++;
            $display("FAIL no_op: got %h expected 0", z_v);
        end
    endtask

    task automatic test_mul();
        load_reg(6, 32'hFFFF_FFFE);
        load_y(6);
        load_reg(8, 32'd3);
        run_op(OP_MUL, 8);
        tests_run++;
        if (z_v !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            tests_failed++;
            $display("FAIL mul_z: got %h expected fffffffffffffffa", z_v);
        end
        Zhighout = 1; HIin = 1;
        step();
        Zlowout = 1; LOin = 1;
        step();
        tests_run++;
        if (hi_v !== 32'hFFFF_FFFF || lo_v !== 32'hFFFF_FFFA) begin
            tests_failed++;
            $display("FAIL mul_hilo: got %h %h expected ffffffff fffffffa", hi_v, lo_v);
        end
    endtask

    task automatic test_div();
        load_reg(6, 32'hFFFF_FFF9);
        load_y(6);
        load_reg(8, 32'd2);
        run_op(OP_DIV, 8);
        tests_run++;
        if (z_v !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            tests_failed++;
            $display("FAIL div_neg: got %h expected fffffffffffffffd", z_v);
        end
        load_reg(6, 32'd7);
        load_y(6);
        load_reg(8, 32'hFFFF_FFFE);
        run_op(OP_DIV, 8);
        tests_run++;
        if (z_v !== 64'h0000_0001_FFFF_FFFD) begin
            tests_failed++;
            $display("FAIL div_negdivisor: got %h expected 00000001fffffffd", z_v);
        end
        load_reg(8, 32'd0);
        run_op(OP_DIV, 8);
        tests_run++;
        if (z_v !== 64'h0) begin
            tests_failed++;
            $display("FAIL div_zero: got %h expected 0", z_v);
        end
    endtask

    task automatic test_bus_misc();
        load_reg(9, 32'hA5A5_A5A5);
        #1;
        tests_run++;
        if (bus_v !== 32'h0) begin
            tests_failed++;
            $display("FAIL bus_idle: got %h expected 0", bus_v);
        end
        InPortout = 1;
        #1;
        tests_run++;
        if (bus_v !== 32'h0) begin
            tests_failed++;
            $display("FAIL bus_inport: got %h expected 0", bus_v);
        end
        MDRout = 1; Cout = 1;
        #1;
        tests_run++;
        if (bus_v !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL bus_mdr_over_c: got %h expected a5a5a5a5", bus_v);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        Zlowout = 1; ops[OP_INC] = 1; Zin = 1;
        step();
        Zlowout = 1; ops[OP_INC] = 1; Zin = 1;
        step();
        tests_run++;
        if (z_v !== 64'h2) begin
            tests_failed++;
            $display("FAIL same_edge_z: got %h expected 2", z_v);
        end
        rout[9] = 1; rin[9] = 1; rin[10] = 1;
        step();
        tests_run++;
        if (r_val[9] !== 32'hA5A5_A5A5 || r_val[10] !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL same_edge_reg: got %h %h expected a5a5a5a5", r_val[9], r_val[10]);
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rin[3] = 1; MDRout = 1;
        clear = 1;
        #1;
        tests_run++;
        if ({r_val[0], r_val[7], r_val[9], hi_v, lo_v, pc_v, ir_v, y_v} !== '0
            || z_v !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: got r0=%h r7=%h r9=%h hi=%h lo=%h pc=%h ir=%h y=%h z=%h",
                     r_val[0], r_val[7], r_val[9], hi_v, lo_v, pc_v, ir_v, y_v, z_v);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (r_val[3] !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_dominates: got %h expected 0", r_val[3]);
        end
        idle();
        clear = 0;
        load_reg(1, 32'h0000_0055);
        tests_run++;
        if (r_val[1] !== 32'h0000_0055) begin
            tests_failed++;
            $display("FAIL reset_resume: got %h expected 00000055", r_val[1]);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shra();
        test_fetch();
        test_shifts();
        test_logic_arith();
        test_priority();
        test_mul();
        test_div();
        test_bus_misc();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
